// File: rtl/d_mem_arb_pkg.sv
// d_mem_arb_pkg: ownership state encoding and counter sizing for the data-memory arbiter
package d_mem_arb_pkg;
  typedef enum logic {
    ARB_CPU_OWN = 1'b0,
    ARB_EXT_OWN = 1'b1
  } arb_state_t;
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction
endpackage

// File: rtl/d_mem_arb_sat_counter.sv
// sat_counter: up-counter that holds at LIMIT-1, clear wins over increment
module sat_counter #(
  parameter int LIMIT = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  // count, saturate, clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(LIMIT - 1)) cnt <= cnt + W'(1);
endmodule

// File: rtl/d_mem_arb.sv
// d_mem_arb: shares the data-memory port between the CPU core and an external loader/debug master
module d_mem_arb
  import d_mem_arb_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [AWIDTH-1:0] ext_addr,
  input  logic [DWIDTH-1:0] ext_wdata,
  output logic [DWIDTH-1:0] ext_rdata,
  output logic              ext_gnt,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_rdata
);
  localparam int WW = cnt_width(STARVE_LIMIT);
  localparam int BW = cnt_width(BURST_MAX);
  arb_state_t state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic ext_own, starved, burst_done;
  logic wait_inc, wait_clr, beat_inc, beat_clr;
  assign ext_own = state == ARB_EXT_OWN;
  assign starved = wait_cnt == WW'(STARVE_LIMIT - 1);
  assign burst_done = beat_cnt == BW'(BURST_MAX - 1);
  // ownership register; the grant is this flop, so it is glitch-free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ARB_CPU_OWN;
    else state <= state_nxt;
  // handover decisions and counter control; the current owner stays muxed in the handover cycle
  always_comb begin
    state_nxt = state;
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    beat_inc = 1'b0;
    beat_clr = 1'b0;
    if (ext_own) begin
      wait_clr = 1'b1;
      beat_inc = ext_req;
      if (!ext_req || (burst_done && cpu_req)) begin
        state_nxt = ARB_CPU_OWN;
        beat_clr = 1'b1;
      end
    end else begin
      beat_clr = 1'b1;
      wait_inc = ext_req && cpu_req;
      wait_clr = !ext_req;
      if (ext_req && (!cpu_req || starved)) begin
        state_nxt = ARB_EXT_OWN;
        wait_clr = 1'b1;
      end
    end
  end
  sat_counter #(.LIMIT(STARVE_LIMIT), .W(WW)) u_wait (
    .clk(clk), .rst_n(rst_n), .inc(wait_inc), .clr(wait_clr), .cnt(wait_cnt)
  );
  sat_counter #(.LIMIT(BURST_MAX), .W(BW)) u_beat (
    .clk(clk), .rst_n(rst_n), .inc(beat_inc), .clr(beat_clr), .cnt(beat_cnt)
  );
  assign ext_gnt = ext_own;
  assign mem_addr = ext_own ? ext_addr : cpu_addr;
  assign mem_wdata = ext_own ? ext_wdata : cpu_wdata;
  assign mem_we = ext_own ? (ext_req && ext_we) : (cpu_req && cpu_we);
  assign cpu_stall = ext_own && cpu_req;
  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;
endmodule

// File: tb/tb_d_mem_arb.sv
// tb_d_mem_arb: scoreboard bench for the data-memory arbiter with a behavioural memory
module tb_d_mem_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [7:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, ext_gnt, mem_we;
  logic [7:0] mem [256];
  logic [7:0] golden [256];
  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  d_mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_gnt(ext_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // behavioural data memory: preset pattern, synchronous write, asynchronous read
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] exp;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (!we) exp_q.push_back(golden[a]);
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || ext_gnt !== 1'b0 || mem_we !== we || mem_addr !== a || (we && mem_wdata !== d)) begin
      errors++;
      $display("FAIL cpu_mux: stall=%b gnt=%b we=%b addr=%h wdata=%h required stall=0 gnt=0 we=%b addr=%h wdata=%h",
               cpu_stall, ext_gnt, mem_we, mem_addr, mem_wdata, we, a, d);
    end
    if (!we) begin
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL cpu_rdata: addr=%h got=%h required=%h", a, cpu_rdata, exp);
      end
    end
    @(posedge clk);
    if (we) golden[a] = d;
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic ext_beat(input logic we, input logic [7:0] a, input logic [7:0] d, output int waited);
    logic [7:0] exp;
    logic got;
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    if (!we) exp_q.push_back(golden[a]);
    waited = 0;
    got = 1'b0;
    while (!got && waited <= 20) begin
      @(negedge clk);
      if (ext_gnt) got = 1'b1;
      else begin
        waited++;
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== (cpu_req && cpu_we)) begin
          errors++;
          $display("FAIL wait_cycle: stall=%b mem_we=%b required stall=0 mem_we=%b", cpu_stall, mem_we, cpu_req && cpu_we);
        end
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: no grant for addr %h after %0d cycles", a, waited);
      if (!we) void'(exp_q.pop_front());
    end else begin
      checks++;
      if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== d) || cpu_stall !== cpu_req) begin
        errors++;
        $display("FAIL ext_mux: we=%b addr=%h wdata=%h stall=%b required we=%b addr=%h wdata=%h stall=%b",
                 mem_we, mem_addr, mem_wdata, cpu_stall, we, a, d, cpu_req);
      end
      if (!we) begin
        exp = exp_q.pop_front();
        checks++;
        if (ext_rdata !== exp) begin
          errors++;
          $display("FAIL ext_rdata: addr=%h got=%h required=%h", a, ext_rdata, exp);
        end
      end
    end
    @(posedge clk);
    if (got && we) golden[a] = d;
    #1;
  endtask

  task automatic ext_release();
    ext_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ext_gnt !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL release_cycle: gnt=%b mem_we=%b required gnt=1 mem_we=0", ext_gnt, mem_we);
    end
    @(negedge clk);
    checks++;
    if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL after_release: gnt=%b stall=%b required gnt=0 stall=0", ext_gnt, cpu_stall);
    end
    @(posedge clk);
    #1;
    ext_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    for (int i = 0; i < 256; i++) golden[i] = 8'(i) ^ 8'hC3;
    #2;
    checks++;
    if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b stall=%b mem_we=%b required 0 0 0", ext_gnt, cpu_stall, mem_we);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cpu_op(1'b1, 8'h10, 8'h5A);
    checks++;
    if (mem[8'h10] !== 8'h5A) begin
      errors++;
      $display("FAIL reset_store: mem[10]=%h required 5a", mem[8'h10]);
    end
    cpu_op(1'b0, 8'h10, 8'h00);
  endtask

  task automatic test_ext_burst();
    int w;
    for (int i = 0; i < 4; i++) begin
      ext_beat(1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i), w);
      checks++;
      if (w !== (i == 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL burst_latency: beat %0d waited %0d required %0d", i, w, i == 0 ? 1 : 0);
      end
    end
    for (int i = 0; i < 4; i++) ext_beat(1'b0, 8'h20 + 8'(i), 8'h00, w);
    ext_release();
  endtask

  task automatic test_starvation();
    int w;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ext_beat(1'b1, 8'h40, 8'h77, w);
    checks++;
    if (w !== 4) begin
      errors++;
      $display("FAIL starve_latency: waited %0d required 4", w);
    end
    ext_release();
    cpu_req = 1'b0;
  endtask

  task automatic test_burst_limit();
    int w;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    for (int i = 0; i < 20; i++) begin
      ext_beat(1'b1, 8'h50 + 8'(i), 8'(i) ^ 8'h3C, w);
      checks++;
      if (w !== (i % 8 == 0 ? 4 : 0)) begin
        errors++;
        $display("FAIL burst_yield: beat %0d waited %0d required %0d", i, w, i % 8 == 0 ? 4 : 0);
      end
    end
    ext_release();
    cpu_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (mem[8'h50 + 8'(i)] !== golden[8'h50 + 8'(i)]) begin
        errors++;
        $display("FAIL burst_data: mem[%h]=%h required %h", 8'h50 + 8'(i), mem[8'h50 + 8'(i)], golden[8'h50 + 8'(i)]);
      end
    end
  endtask

  task automatic test_write_isolation();
    int w;
    ext_beat(1'b0, 8'h30, 8'h00, w);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'hFF;
    ext_beat(1'b0, 8'h30, 8'h00, w);
    cpu_req = 1'b0; cpu_we = 1'b0;
    ext_release();
    checks++;
    if (mem[8'h30] !== golden[8'h30]) begin
      errors++;
      $display("FAIL isolation: mem[30]=%h required %h", mem[8'h30], golden[8'h30]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    ext_beat(1'b1, 8'h60, 8'h11, w);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h61; ext_wdata = 8'h99;
    @(negedge clk);
    checks++;
    if (ext_gnt !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL midburst_pre: gnt=%b mem_we=%b required 1 1", ext_gnt, mem_we);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: gnt=%b stall=%b mem_we=%b required 0 0 0", ext_gnt, cpu_stall, mem_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[8'h61] !== golden[8'h61]) begin
      errors++;
      $display("FAIL midburst_nowrite: mem[61]=%h required %h", mem[8'h61], golden[8'h61]);
    end
    ext_req = 1'b0; ext_we = 1'b0;
    rst_n = 1'b1;
    cpu_op(1'b1, 8'h61, 8'h12);
    cpu_op(1'b0, 8'h61, 8'h00);
    cpu_op(1'b0, 8'h60, 8'h00);
  endtask

  initial begin
    test_reset();
    test_ext_burst();
    test_starvation();
    test_burst_limit();
    test_write_isolation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
